// File: rtl/validator_feeder_if.sv
// Result stream from validator_feeder to its consumer.
// Handshake: a transfer happens on a rising clock edge where res_valid and
// res_ready are both 1. While res_valid is 1 and res_ready is 0, res_index,
// res_inlier and res_timeout hold their values. res_valid never drops
// without a transfer, except under reset.
interface validator_feeder_if #(
  parameter int ADDR_W = 16
);
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_index;
  logic              res_inlier;
  logic              res_timeout;

  modport master (
    output res_valid, res_index, res_inlier, res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_index, res_inlier, res_timeout,
    output res_ready
  );
endinterface

// File: rtl/validator_feeder.sv
// Sequencer in front of validator_core. It takes each stored point in turn
// as the point under test, clears the core, then streams the whole cloud in
// batches of DISTANCE_MODULES lanes until the core returns a verdict or the
// watchdog expires. Each verdict leaves on the result stream.
// batch_rdata layout: lane n holds {z,y,x} in bits [(n+1)*3N-1 : n*3N].
module validator_feeder #(
  parameter int             N                = 16,
  parameter int             DISTANCE_MODULES = 32,
  parameter int             ADDR_W           = 16,
  parameter int             DIST_LATENCY     = 2,
  parameter logic [N-1:0]   SENTINEL         = 16'h7FFF,
  parameter int             VERDICT_TIMEOUT  = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [2*N-1:0]                   point_cloud_size,
  output logic [ADDR_W-1:0]                pt_addr,
  input  logic [3*N-1:0]                   pt_rdata,
  output logic [ADDR_W-1:0]                batch_addr,
  input  logic [3*N*DISTANCE_MODULES-1:0]  batch_rdata,
  output logic                             core_reset,
  output logic [N-1:0]                     point_x,
  output logic [N-1:0]                     point_y,
  output logic [N-1:0]                     point_z,
  output logic [N*DISTANCE_MODULES-1:0]    cp_x,
  output logic [N*DISTANCE_MODULES-1:0]    cp_y,
  output logic [N*DISTANCE_MODULES-1:0]    cp_z,
  input  logic                             core_inlier,
  input  logic                             core_outlier,
  validator_feeder_if.master               res,
  output logic                             busy,
  output logic                             done,
  output logic [2:0]                       dbg_state
);

  localparam int DM    = DISTANCE_MODULES;
  localparam int SW    = 2 * N;
  localparam int WD_W  = $clog2(VERDICT_TIMEOUT + 1);
  localparam int LAT_W = $clog2(DIST_LATENCY + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_WAIT   = 3'd4,
    S_EMIT   = 3'd5
  } state_t;

  state_t            state;
  logic [SW-1:0]     size_r;
  logic [SW-1:0]     last_b;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] b;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_b;
  logic [LAT_W-1:0]  lat_cnt;
  logic [WD_W-1:0]   wd_cnt;

  logic [SW-1:0]     last_b_calc;
  logic [N*DM-1:0]   mx, my, mz;
  logic              verdict_ok;

  assign pt_addr    = idx;
  assign batch_addr = b;
  assign dbg_state  = state;

  // Index of the final batch, rounding the batch count up.
  assign last_b_calc = (point_cloud_size + SW'(DM - 1)) / SW'(DM) - SW'(1);

  // A verdict counts only once the core is out of its clear.
  assign verdict_ok = (core_inlier | core_outlier) && !core_reset &&
                      (state == S_STREAM || state == S_WAIT);

  // Lanes beyond the cloud or equal to the point under test are hidden.
  function automatic logic lane_masked(input logic [ADDR_W-1:0] bb,
                                       input int lane,
                                       input logic [SW-1:0] sz,
                                       input logic [ADDR_W-1:0] pi);
    logic [SW-1:0] g;
    g = SW'(bb) * SW'(DM) + SW'(lane);
    return (g >= sz) || (g == SW'(pi));
  endfunction

  // Masked view of the batch returning from memory this cycle.
  always_comb begin
    mx = '0;
    my = '0;
    mz = '0;
    for (int n = 0; n < DM; n++) begin
      if (lane_masked(rd_b, n, size_r, idx)) begin
        mx[n*N +: N] = SENTINEL;
        my[n*N +: N] = SENTINEL;
        mz[n*N +: N] = SENTINEL;
      end else begin
        mx[n*N +: N] = batch_rdata[n*3*N +: N];
        my[n*N +: N] = batch_rdata[n*3*N + N +: N];
        mz[n*N +: N] = batch_rdata[n*3*N + 2*N +: N];
      end
    end
  end

  // Sequencer: point selection, batch streaming, core clear timing, results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      size_r          <= '0;
      last_b          <= '0;
      idx             <= '0;
      b               <= '0;
      rd_valid        <= 1'b0;
      rd_b            <= '0;
      lat_cnt         <= '0;
      wd_cnt          <= '0;
      core_reset      <= 1'b1;
      point_x         <= '0;
      point_y         <= '0;
      point_z         <= '0;
      cp_x            <= '0;
      cp_y            <= '0;
      cp_z            <= '0;
      res.res_valid   <= 1'b0;
      res.res_index   <= '0;
      res.res_inlier  <= 1'b0;
      res.res_timeout <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;

      // The cp bus carries a masked batch the cycle after its read,
      // otherwise all-SENTINEL so the core sees no stale points.
      if (state != S_IDLE) begin
        if (rd_valid) begin
          cp_x <= mx;
          cp_y <= my;
          cp_z <= mz;
        end else begin
          cp_x <= {DM{SENTINEL}};
          cp_y <= {DM{SENTINEL}};
          cp_z <= {DM{SENTINEL}};
        end
      end

      // Release the core once batch 0 has sat on cp for DIST_LATENCY cycles.
      if (state == S_STREAM || state == S_WAIT) begin
        if (rd_valid && rd_b == '0) begin
          lat_cnt <= LAT_W'(1);
        end else if (core_reset && lat_cnt != '0) begin
          if (lat_cnt == LAT_W'(DIST_LATENCY)) core_reset <= 1'b0;
          else                                 lat_cnt    <= lat_cnt + LAT_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          core_reset <= 1'b1;
          busy       <= 1'b0;
          if (start) begin
            size_r <= point_cloud_size;
            last_b <= last_b_calc;
            idx    <= '0;
            if (point_cloud_size == '0) begin
              done <= 1'b1;
            end else begin
              busy  <= 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          point_x <= pt_rdata[N-1:0];
          point_y <= pt_rdata[2*N-1:N];
          point_z <= pt_rdata[3*N-1:2*N];
          b       <= '0;
          lat_cnt <= '0;
          state   <= S_STREAM;
        end
        S_STREAM: begin
          if (verdict_ok) begin
            state           <= S_EMIT;
            core_reset      <= 1'b1;
            lat_cnt         <= '0;
            res.res_valid   <= 1'b1;
            res.res_index   <= idx;
            res.res_inlier  <= core_inlier;
            res.res_timeout <= 1'b0;
          end else begin
            rd_valid <= 1'b1;
            rd_b     <= b;
            if (SW'(b) == last_b) begin
              wd_cnt <= '0;
              state  <= S_WAIT;
            end else begin
              b <= b + ADDR_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (verdict_ok || wd_cnt == WD_W'(VERDICT_TIMEOUT - 1)) begin
            state           <= S_EMIT;
            core_reset      <= 1'b1;
            lat_cnt         <= '0;
            res.res_valid   <= 1'b1;
            res.res_index   <= idx;
            res.res_inlier  <= verdict_ok && core_inlier;
            res.res_timeout <= !verdict_ok;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_EMIT: begin
          core_reset <= 1'b1;
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            if (SW'(idx) == size_r - SW'(1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_validator_feeder.sv
// Bench for validator_feeder with DM=4 and a short watchdog. Memories and a
// behavioural core are modelled here; results are checked against an
// expected queue and cp batches against a second queue.
module tb_validator_feeder;

  localparam int N    = 16;
  localparam int DM   = 4;
  localparam int AW   = 16;
  localparam int DL   = 2;
  localparam int TO   = 8;
  localparam int CW   = 3 * N * DM;
  localparam logic [N-1:0]  SENT     = 16'h7FFF;
  localparam logic [CW-1:0] ALL_SENT = {(3*DM){SENT}};

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic              start = 1'b0;
  logic [2*N-1:0]    point_cloud_size = '0;
  logic [AW-1:0]     pt_addr, batch_addr;
  logic [3*N-1:0]    pt_rdata = '0;
  logic [CW-1:0]     batch_rdata = '0;
  logic              core_reset;
  logic [N-1:0]      point_x, point_y, point_z;
  logic [N*DM-1:0]   cp_x, cp_y, cp_z;
  logic              core_inlier = 1'b0;
  logic              core_outlier = 1'b0;
  logic              busy, done;
  logic [2:0]        dbg_state;

  validator_feeder_if #(.ADDR_W(AW)) res_if ();

  validator_feeder #(
    .N(N), .DISTANCE_MODULES(DM), .ADDR_W(AW), .DIST_LATENCY(DL),
    .SENTINEL(SENT), .VERDICT_TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .point_cloud_size(point_cloud_size),
    .pt_addr(pt_addr), .pt_rdata(pt_rdata),
    .batch_addr(batch_addr), .batch_rdata(batch_rdata),
    .core_reset(core_reset),
    .point_x(point_x), .point_y(point_y), .point_z(point_z),
    .cp_x(cp_x), .cp_y(cp_y), .cp_z(cp_z),
    .core_inlier(core_inlier), .core_outlier(core_outlier),
    .res(res_if.master),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // scoreboard state
  int n_chk = 0;
  int n_err = 0;
  logic [AW+1:0] exp_q[$];
  logic [CW-1:0] cp_exp_q[$];
  int core_mode = 0;
  bit cp_mon_en = 0;
  bit early_en = 0;
  bit early_pend = 0;
  logic [CW-1:0] last_cp = '0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3*N-1:0] pt_word(input int k);
    return {16'(7*k + 3), 16'(5*k + 2), 16'(3*k + 1)};
  endfunction

  function automatic logic [CW-1:0] exp_batch(input int bb, input int i, input int sz);
    logic [N*DM-1:0] ex, ey, ez;
    logic [3*N-1:0] w;
    for (int l = 0; l < DM; l++) begin
      int k;
      k = bb * DM + l;
      w = pt_word(k);
      if (k >= sz || k == i) begin
        ex[l*N +: N] = SENT; ey[l*N +: N] = SENT; ez[l*N +: N] = SENT;
      end else begin
        ex[l*N +: N] = w[N-1:0]; ey[l*N +: N] = w[2*N-1:N]; ez[l*N +: N] = w[3*N-1:2*N];
      end
    end
    return {ez, ey, ex};
  endfunction

  // point and batch memories, one-cycle read latency
  always @(posedge clock) begin
    pt_rdata <= pt_word(int'(pt_addr));
    for (int l = 0; l < DM; l++)
      batch_rdata[l*3*N +: 3*N] <= pt_word(int'(batch_addr) * DM + l);
  end

  // behavioural core: answers as soon as it is out of reset
  always begin
    @(posedge clock); #1;
    if (core_reset) begin
      core_inlier = 1'b0; core_outlier = 1'b0;
    end else begin
      case (core_mode)
        0: begin core_inlier = point_x[0]; core_outlier = ~point_x[0]; end
        1: begin core_inlier = 1'b1; core_outlier = 1'b1; end
        3: begin core_inlier = 1'b1; core_outlier = 1'b0; end
        default: begin core_inlier = 1'b0; core_outlier = 1'b0; end
      endcase
    end
  end

  // monitors, sampled on the falling edge
  always @(negedge clock) begin
    logic [CW-1:0] cp_cat;
    cp_cat = {cp_z, cp_y, cp_x};
    if (reset) begin
      if (res_if.res_valid) begin
        if (exp_q.size() == 0) check("res_unexpected", res_if.res_valid, 0);
        else begin
          check("res_fields", {res_if.res_index, res_if.res_inlier, res_if.res_timeout}, exp_q[0]);
          if (res_if.res_ready) void'(exp_q.pop_front());
        end
      end
      if (cp_mon_en && cp_cat != last_cp && cp_cat != ALL_SENT && cp_cat != '0) begin
        if (cp_exp_q.size() == 0) check("cp_extra", cp_cat, ALL_SENT);
        else check("cp_batch", cp_cat, cp_exp_q.pop_front());
      end
      if (early_en && core_inlier && !core_reset) begin
        check("early_baddr", batch_addr, 4);
        early_pend = 1;
      end else if (early_pend) begin
        check("early_hold", batch_addr, 4);
        check("early_emit", res_if.res_valid, 1);
        early_pend = 0;
      end
    end
    last_cp = cp_cat;
  end

  // driver tasks
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic pulse_start(input int sz);
    point_cloud_size = 32'(sz);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clock);
      n++;
      if (done) break;
    end
    check(tag, done, 1);
    tick();
  endtask

  task automatic push_results(input int sz, input int mode);
    for (int k = 0; k < sz; k++) begin
      case (mode)
        0: exp_q.push_back({16'(k), (k % 2 == 0), 1'b0});
        2: exp_q.push_back({16'(k), 1'b0, 1'b1});
        default: exp_q.push_back({16'(k), 1'b1, 1'b0});
      endcase
    end
  endtask

  initial begin
    int n;
    res_if.res_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_core_reset", core_reset, 1);
    check("rst_res_valid", res_if.res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_batch_addr", batch_addr, 0);
    check("rst_pt_addr", pt_addr, 0);
    check("rst_point_x", point_x, 0);
    check("rst_cp_x", cp_x, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    tick();

    // empty cloud
    pulse_start(0);
    wait_done("size0_done", 10, n);
    check("size0_latency", n, 1);
    @(negedge clock);
    check("size0_pulse", done, 0);
    check("size0_busy", busy, 0);
    tick();

    // six points, two batches each, with a start while busy
    core_mode = 0;
    push_results(6, 0);
    for (int i = 0; i < 6; i++) begin
      cp_exp_q.push_back(exp_batch(0, i, 6));
      cp_exp_q.push_back(exp_batch(1, i, 6));
    end
    cp_mon_en = 1;
    pulse_start(6);
    repeat (5) tick();
    check("run6_busy", busy, 1);
    pulse_start(3);
    wait_done("run6_done", 400, n);
    cp_mon_en = 0;
    check("run6_res_left", exp_q.size(), 0);
    check("run6_cp_left", cp_exp_q.size(), 0);
    @(negedge clock);
    check("run6_idle_busy", busy, 0);
    tick();

    // early exit on inlier
    core_mode = 3;
    push_results(40, 3);
    early_en = 1;
    pulse_start(40);
    wait_done("early_done", 2000, n);
    early_en = 0;
    check("early_res_left", exp_q.size(), 0);

    // inlier and outlier together
    core_mode = 1;
    push_results(2, 1);
    pulse_start(2);
    wait_done("both_done", 200, n);
    check("both_res_left", exp_q.size(), 0);

    // watchdog
    core_mode = 2;
    push_results(2, 2);
    pulse_start(2);
    n = 0;
    while (n < 60) begin
      @(negedge clock);
      n++;
      if (res_if.res_valid) break;
    end
    check("to_latency", n, 3 + TO + 1);
    tick();
    wait_done("to_done", 200, n);
    check("to_res_left", exp_q.size(), 0);

    // back-pressure
    core_mode = 0;
    push_results(3, 0);
    res_if.res_ready = 1'b0;
    pulse_start(3);
    n = 0;
    while (n < 60 && !res_if.res_valid) begin
      @(negedge clock);
      n++;
    end
    check("stall_valid", res_if.res_valid, 1);
    repeat (5) begin
      @(negedge clock);
      check("stall_hold", res_if.res_valid, 1);
    end
    @(posedge clock); #1;
    res_if.res_ready = 1'b1;
    wait_done("stall_done", 200, n);
    check("stall_res_left", exp_q.size(), 0);

    // reset in the middle of streaming
    core_mode = 2;
    pulse_start(40);
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    check("mrst_core_reset", core_reset, 1);
    check("mrst_res_valid", res_if.res_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_batch_addr", batch_addr, 0);
    check("mrst_cp_x", cp_x, 0);
    check("mrst_point_x", point_x, 0);
    tick();
    reset = 1'b1;
    tick();
    core_mode = 0;
    push_results(6, 0);
    pulse_start(6);
    wait_done("mrst_rerun_done", 400, n);
    check("mrst_res_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // overall time limit
  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
